// File: rtl/kinase_assay_sequencer.sv
// Protocol sequencer for the dual-lane kinase assay: load, mix, incubate, wash, elute.
// Both lanes share one valve set, so a single FSM drives every registered valve output.
module kinase_assay_sequencer #(
    parameter int DW       = 16,
    parameter int PUMP_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] load_len,
    input  logic [DW-1:0] mix_len,
    input  logic [DW-1:0] inc_len,
    input  logic [DW-1:0] wash_len,
    input  logic [DW-1:0] elute_len,
    output logic [12:0]   c,
    output logic [3:0]    s,
    output logic [4:0]    p,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [2:0]    state
);
    localparam int DIVW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MIX   = 3'd2,
        INC   = 3'd3,
        WASH  = 3'd4,
        ELUTE = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      phase_reg, phase_next;
    logic [DIVW-1:0] div_reg, div_next;
    logic            tog_reg, tog_next;
    logic            aborted_next;
    logic            accept_start;
    logic [DW-1:0]   cfg_reg [5];
    logic [DW-1:0]   len_in [5];
    logic [DW-1:0]   next_len;

    assign len_in[0] = load_len;
    assign len_in[1] = mix_len;
    assign len_in[2] = inc_len;
    assign len_in[3] = wash_len;
    assign len_in[4] = elute_len;
    assign accept_start = (state_reg == IDLE) && start && !abort;
    assign state = state_reg;

    // A zero-length step still occupies one cycle, so the counter never underflows.
    function automatic logic [DW-1:0] dwell(input logic [DW-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    function automatic logic [21:0] valve_map(input state_t st, input logic [2:0] ph,
                                              input logic tg);
        logic [12:0] cv;
        logic [3:0]  sv;
        logic [4:0]  pv;
        cv = 13'h1FFF;
        sv = 4'hF;
        pv = 5'h1F;
        case (st)
            LOAD:  cv = 13'h1FF0;
            MIX: begin
                case (ph)
                    3'd0:    pv = 5'b11_011;
                    3'd1:    pv = 5'b11_001;
                    3'd2:    pv = 5'b11_101;
                    3'd3:    pv = 5'b11_100;
                    3'd4:    pv = 5'b11_110;
                    default: pv = 5'b11_010;
                endcase
            end
            WASH: begin
                cv = 13'h1E0F;
                pv = tg ? 5'b10_111 : 5'b01_111;
            end
            ELUTE: begin
                cv = 13'h01FF;
                sv = 4'h0;
            end
            default: ;
        endcase
        return {cv, sv, pv};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) cfg_reg[i] <= '0;
        end else if (accept_start) begin
            for (int i = 0; i < 5; i++) cfg_reg[i] <= len_in[i];
        end
    end

    always_comb begin
        next_len = '0;
        case (state_reg)
            LOAD:    next_len = cfg_reg[1];
            MIX:     next_len = cfg_reg[2];
            INC:     next_len = cfg_reg[3];
            WASH:    next_len = cfg_reg[4];
            default: next_len = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        phase_next   = phase_reg;
        div_next     = div_reg;
        tog_next     = tog_reg;
        aborted_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept_start) begin
                    state_next = LOAD;
                    cnt_next   = dwell(load_len);
                end
            end
            DONE: state_next = IDLE;
            default: begin
                if (abort) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                end else if (cnt_reg == '0) begin
                    // Step exit: pump phase and wash toggle restart for the next step.
                    state_next = state_t'(state_reg + 3'd1);
                    cnt_next   = dwell(next_len);
                    div_next   = '0;
                    phase_next = '0;
                    tog_next   = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                    if (div_reg == DIVW'(PUMP_DIV - 1)) begin
                        div_next = '0;
                        if (state_reg == MIX)
                            phase_next = (phase_reg == 3'd5) ? 3'd0 : phase_reg + 3'd1;
                        if (state_reg == WASH)
                            tog_next = ~tog_reg;
                    end else begin
                        div_next = div_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            phase_reg <= '0;
            div_reg   <= '0;
            tog_reg   <= 1'b0;
            c         <= 13'h1FFF;
            s         <= 4'hF;
            p         <= 5'h1F;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            div_reg      <= div_next;
            tog_reg      <= tog_next;
            {c, s, p}    <= valve_map(state_next, phase_next, tog_next);
            busy         <= (state_next != IDLE);
            done         <= (state_next == DONE);
            aborted      <= aborted_next;
        end
    end
endmodule

// File: tb/tb_kinase_assay_sequencer.sv
// Bench for kinase_assay_sequencer: two instances (PUMP_DIV=4 and 1) share stimulus,
// expected per-cycle output vectors are queued at start and popped every cycle.
module tb_kinase_assay_sequencer;
    typedef logic [27:0] obs_t;   // {state, c, s, p, busy, done, aborted}

    localparam logic [2:0] PUMP_TAB [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    logic        clk, rst, start, abort;
    logic [15:0] load_len, mix_len, inc_len, wash_len, elute_len;
    logic [12:0] c4, c1;
    logic [3:0]  s4, s1;
    logic [4:0]  p4, p1;
    logic        busy4, busy1, done4, done1, ab4, ab1;
    logic [2:0]  st4, st1;
    obs_t        o4, o1;
    obs_t        q4[$], q1[$];
    int          cur_len[5];
    int          total = 0;
    int          bad = 0;
    logic [2:0]  prev_st1;
    logic [4:0]  prev_p1;

    kinase_assay_sequencer #(.DW(16), .PUMP_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .load_len(load_len), .mix_len(mix_len), .inc_len(inc_len),
        .wash_len(wash_len), .elute_len(elute_len),
        .c(c4), .s(s4), .p(p4), .busy(busy4), .done(done4), .aborted(ab4), .state(st4)
    );

    kinase_assay_sequencer #(.DW(16), .PUMP_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .load_len(load_len), .mix_len(mix_len), .inc_len(inc_len),
        .wash_len(wash_len), .elute_len(elute_len),
        .c(c1), .s(s1), .p(p1), .busy(busy1), .done(done1), .aborted(ab1), .state(st1)
    );

    assign o4 = {st4, c4, s4, p4, busy4, done4, ab4};
    assign o1 = {st1, c1, s1, p1, busy1, done1, ab1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t vec(input int st, input int ph, input int tg,
                                 input bit dn, input bit ab);
        logic [12:0] cv;
        logic [3:0]  sv;
        logic [4:0]  pv;
        logic [2:0]  stv;
        cv = 13'h1FFF;
        sv = 4'hF;
        pv = 5'h1F;
        case (st)
            1: cv = 13'h1FF0;
            2: pv = {2'b11, PUMP_TAB[ph]};
            4: begin
                cv = 13'h1E0F;
                pv = {(tg != 0) ? 2'b10 : 2'b01, 3'b111};
            end
            5: begin
                cv = 13'h01FF;
                sv = 4'h0;
            end
            default: ;
        endcase
        stv = 3'(st);
        return {stv, cv, sv, pv, (st != 0), dn, ab};
    endfunction

    task automatic set_lens(input int a, input int b, input int cc, input int d, input int e);
        cur_len = '{a, b, cc, d, e};
        load_len = 16'(a); mix_len = 16'(b); inc_len = 16'(cc);
        wash_len = 16'(d); elute_len = 16'(e);
    endtask

    // Queue the expected outputs of a run; cut >= 0 stops after that many step cycles.
    task automatic push_run(input int cut);
        int n;
        int len;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            len = (cur_len[k] == 0) ? 1 : cur_len[k];
            for (int i = 0; i < len; i++) begin
                if (cut >= 0 && n >= cut) return;
                q4.push_back(vec(k + 1, (i / 4) % 6, (i / 4) % 2, 1'b0, 1'b0));
                q1.push_back(vec(k + 1, i % 6, i % 2, 1'b0, 1'b0));
                n++;
            end
        end
        q4.push_back(vec(6, 0, 0, 1'b1, 1'b0));
        q1.push_back(vec(6, 0, 0, 1'b1, 1'b0));
    endtask

    task automatic tick();
        obs_t e4, e1;
        prev_st1 = st1;
        prev_p1  = p1;
        @(posedge clk);
        #1;
        e4 = (q4.size() > 0) ? q4.pop_front() : vec(0, 0, 0, 1'b0, 1'b0);
        e1 = (q1.size() > 0) ? q1.pop_front() : vec(0, 0, 0, 1'b0, 1'b0);
        total++;
        assert (o4 === e4) else begin
            bad++;
            $error("FAIL outputs_div4 t=%0t observed=%h expected=%h", $time, o4, e4);
        end
        total++;
        assert (o1 === e1) else begin
            bad++;
            $error("FAIL outputs_div1 t=%0t observed=%h expected=%h", $time, o1, e1);
        end
        if (st1 == 3'd2 && prev_st1 == 3'd2) begin
            total++;
            assert ($countones(p1[2:0] ^ prev_p1[2:0]) === 1) else begin
                bad++;
                $error("FAIL pump_one_bit t=%0t observed=%b->%b expected=one bit change",
                       $time, prev_p1[2:0], p1[2:0]);
            end
        end
    endtask

    task automatic drain();
        while (q4.size() > 0) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_lens(0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reference run: 3,12,2,8,2; done lands 28 cycles after start.
        set_lens(3, 12, 2, 8, 2);
        push_run(-1);
        start = 1'b1; tick(); start = 1'b0;
        drain();
        tick(); tick();

        // All-zero lengths, then back-to-back start on the IDLE cycle after DONE.
        set_lens(0, 0, 0, 0, 0);
        push_run(-1);
        start = 1'b1; tick(); start = 1'b0;
        drain();
        tick();
        set_lens(1, 2, 1, 3, 1);
        push_run(-1);
        start = 1'b1; tick(); start = 1'b0;
        drain();
        tick();

        // Long mix: the PUMP_DIV=1 instance wraps its phase repeatedly.
        set_lens(1, 30, 1, 1, 1);
        push_run(-1);
        start = 1'b1; tick(); start = 1'b0;
        drain();
        tick();

        // Abort on the 4th WASH cycle.
        set_lens(3, 12, 2, 8, 2);
        push_run(3 + 12 + 2 + 4);
        start = 1'b1; tick(); start = 1'b0;
        drain();
        q4.push_back(vec(0, 0, 0, 1'b0, 1'b1));
        q1.push_back(vec(0, 0, 0, 1'b0, 1'b1));
        abort = 1'b1; tick(); abort = 1'b0;
        tick();

        // Restart; lengths change and start pulses again mid-run without effect.
        push_run(-1);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        set_lens(7, 5, 9, 4, 6);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        start = 1'b1; tick(); start = 1'b0;
        drain();
        tick();

        // Reset in MIX gives reset values with no done or aborted pulse.
        set_lens(3, 12, 2, 8, 2);
        push_run(3 + 5);
        start = 1'b1; tick(); start = 1'b0;
        drain();
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();

        // start and abort together in IDLE: nothing happens.
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0; tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
